// File: rtl/wide_add_sequencer_if.sv
// Operand, slice-adder and result signals of the wide-add sequencer.
// slave is the sequencer's view; master is the surrounding logic (operand source, adder slice, result sink).
interface wide_add_sequencer_if #(
   parameter int N = 32,
   parameter int K = 4
);
   localparam int W = N * K;

   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_ci;

   logic [N-1:0]  slice_a;
   logic [N-1:0]  slice_b;
   logic          slice_ci;
   logic [N-1:0]  slice_so;
   logic          slice_co;

   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic          out_co;
   logic          out_ov;

   modport slave (
      input  in_valid, in_a, in_b, in_ci, slice_so, slice_co, out_ready,
      output in_ready, slice_a, slice_b, slice_ci, out_valid, out_sum, out_co, out_ov
   );

   modport master (
      output in_valid, in_a, in_b, in_ci, slice_so, slice_co, out_ready,
      input  in_ready, slice_a, slice_b, slice_ci, out_valid, out_sum, out_co, out_ov
   );
endinterface

// File: rtl/wide_add_sequencer.sv
// Feeds a W = N*K bit add through an external N-bit combinational adder slice,
// one chunk per cycle LSB first, rippling the carry through a register.
module wide_add_sequencer #(
   parameter int N = 32,
   parameter int K = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   wide_add_sequencer_if.slave    bus
);
   localparam int W     = N * K;
   localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic [W-1:0]       sum_q, sum_d;
   logic [W-1:0]       res_sum_q, res_sum_d;
   logic               res_co_q, res_co_d;
   logic               res_ov_q, res_ov_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         carry_q   <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         sum_q     <= '0;
         res_sum_q <= '0;
         res_co_q  <= 1'b0;
         res_ov_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         carry_q   <= carry_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sum_q     <= sum_d;
         res_sum_q <= res_sum_d;
         res_co_q  <= res_co_d;
         res_ov_q  <= res_ov_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      carry_d   = carry_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      res_sum_d = res_sum_q;
      res_co_d  = res_co_q;
      res_ov_d  = res_ov_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.in_a;
               b_d     = bus.in_b;
               carry_d = bus.in_ci;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int i = 0; i < K; i++) begin
               if (int'(idx_q) == i) sum_d[i*N +: N] = bus.slice_so;
            end
            carry_d = bus.slice_co;
            if (idx_q == LAST_IDX) begin
               // Result registers are loaded once, so they stay put through DONE and afterwards.
               state_d   = DONE;
               res_sum_d = sum_d;
               res_co_d  = bus.slice_co;
               res_ov_d  = (a_q[W-1] == b_q[W-1]) && (sum_d[W-1] != a_q[W-1]);
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == DONE);
      bus.slice_a   = '0;
      bus.slice_b   = '0;
      bus.slice_ci  = 1'b0;
      if (state_q == RUN) begin
         for (int i = 0; i < K; i++) begin
            if (int'(idx_q) == i) begin
               bus.slice_a = a_q[i*N +: N];
               bus.slice_b = b_q[i*N +: N];
            end
         end
         bus.slice_ci = carry_q;
      end
   end

   assign bus.out_sum = res_sum_q;
   assign bus.out_co  = res_co_q;
   assign bus.out_ov  = res_ov_q;
endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-cycle wide-operand adder controller that sits directly upstream and downstream of the team's combinational N-bit ripple-carry adder slice. It accepts one W = N·K bit operand pair over a valid/ready handshake and feeds the external slice one N-bit chunk per cycle, LSB chunk first. It captures each slice sum, registers the slice carry-out into the next chunk's carry-in, and presents the assembled W-bit result over a second valid/ready handshake. The result is a 128-bit add from one 32-bit adder instance in K cycles, with no wider carry chain.

## Interface
- N, default 32: slice width; must match the attached adder's N; N ≥ 1
- K, default 4: number of slices; W = N·K; K ≥ 1
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  block can accept operands
- in_a  input  W  operand A
- in_b  input  W  operand B
- in_ci  input  1  carry-in to bit 0
- slice_a  output  N  chunk of A to adder ia
- slice_b  output  N  chunk of B to adder ib
- slice_ci  output  1  carry to adder ci
- slice_so  input  N  adder sum so (combinational return)
- slice_co  input  1  adder carry-out co
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_sum  output  W  (in_a + in_b + in_ci) mod 2^W
- out_co  output  1  carry out of bit W-1
- out_ov  output  1  two's-complement overflow

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - If in_valid, latch in_a, in_b into a_reg, b_reg.
  - carry_reg←in_ci; idx←0; go to RUN.
- RUN:
  - slice_a=a_reg[idx·N +: N], slice_b=b_reg[idx·N +: N], slice_ci=carry_reg.
  - Each edge: sum_reg[idx·N +: N]←slice_so; carry_reg←slice_co.
  - If idx==K-1, go to DONE; else idx←idx+1.
  - idx is ⌈log2 K⌉ bits, minimum 1.
- DONE:
  - out_valid=1; out_sum=sum_reg; out_co=carry_reg.
  - out_ov=(a_reg[W-1]==b_reg[W-1]) && (sum_reg[W-1]!=a_reg[W-1]).
  - If out_ready, go to IDLE.
- Outside RUN: slice_a, slice_b and slice_ci are driven 0.
- in_ready is 1 only in IDLE. In RUN and DONE, in_valid is ignored and no operands are captured.
- out_valid is 1 only in DONE. out_sum, out_co and out_ov hold stable until the handshake completes.
- out_sum/out_co/out_ov are registered values. They keep the last result after DONE→IDLE and are 0 from reset until the first result.
- K=1: a single RUN cycle, then DONE.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, idx=0, carry_reg=0, a_reg=b_reg=sum_reg=0. Outputs are in_ready=1, out_valid=0, out_sum=0, out_co=0, out_ov=0, slice_*=0.
- Reset mid-RUN or mid-DONE aborts the transaction: out_valid drops immediately and no partial result is presented.
- The first edge after rst_n deasserts may accept operands.
- Latency: operands accepted at edge E0; out_valid rises after edge E0+K.
- Throughput with out_ready held 1: one result per K+2 cycles (accept cycle, K RUN cycles, 1 DONE cycle).
- The external slice is combinational. slice_so/slice_co must settle within one clk period of slice_a/b/ci changing, and they are sampled only in RUN.
- Result transfer occurs on any edge with out_valid && out_ready. If out_ready is already high on DONE entry, the transfer occurs on the first DONE edge.

## Test plan
- Reset: assert rst_n=0 mid-cycle.
  - Required: in_ready=1, out_valid=0, out_sum=0, out_co=0 asynchronously, with no clock edge needed.
- Full ripple (N=32, K=4): in_a=2^128-1, in_b=1, in_ci=0.
  - Required: out_sum=0, out_co=1, out_ov=0.
  - slice_ci must be 1 in RUN cycles 1..3.
  - out_valid rises exactly 4 edges after accept.
- Signed overflow: in_a=2^127-1, in_b=1, in_ci=0.
  - Required: out_sum=2^127, out_co=0, out_ov=1.
- Carry-in only: in_a=in_b=0, in_ci=1.
  - Required: out_sum=1, out_co=0, out_ov=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, while in_valid=1 with new operands.
  - Required: out_sum/out_co/out_ov remain stable and in_ready=0 throughout.
  - The new operands are accepted only on the first IDLE edge after out_ready=1.
  - The second result is correct.
- Abort and back-to-back: pulse rst_n low during RUN idx=2.
  - Required: IDLE, out_valid=0.
  - Then issue 3 back-to-back transactions with random operands and out_ready=1. Results must match a reference sum and arrive every 6 cycles.
